// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file writeback path: request payload,
// register-file geometry and scoreboard index helpers.
package cpu_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int DATA_W        = 32;
    localparam int NUM_BANK_REGS = 64;

    typedef struct packed {
        logic                 fbank;
        logic [REG_IDX_W-1:0] rw;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    // Scoreboard bit for {bank, reg}.
    function automatic logic [NUM_BANK_REGS-1:0] sb_onehot(input logic fbank, input logic [REG_IDX_W-1:0] r);
        sb_onehot = {{(NUM_BANK_REGS-1){1'b0}}, 1'b1} << {fbank, r};
    endfunction

    function automatic logic is_int_r0(input logic fbank, input logic [REG_IDX_W-1:0] r);
        is_int_r0 = (fbank == 1'b0) && (r == {REG_IDX_W{1'b0}});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester after the last accepted index wins.
// Reusable for any N-way port sharing; the pointer only moves on accept.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             accept,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;

    // Pointer register; reset to N-1 so source 0 leads the first contest.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_r <= IDX_W'(N - 1);
        end else if (accept) begin
            ptr_r <= idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Scan from pointer+1 and grant the first active request.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s      = IDX_W'((int'(ptr_r) + k) % N);
            hit_s       = en && !found_s && req[cand_s];
            gnt[cand_s] = hit_s;
            idx         = hit_s ? cand_s : idx;
            found_s     = found_s | hit_s;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N writeback sources and keeps the
// {bank,reg} pending-write scoreboard the issue stage uses for RAW checks.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int N       = 4,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_fbank,
    input  logic [REG_IDX_W*N-1:0] req_rw,
    input  logic [DATA_W*N-1:0]    req_data,
    output logic [N-1:0]           req_ready,
    input  logic                   wb_hold,
    output logic                   wb_en,
    output logic                   wb_fbank,
    output logic [REG_IDX_W-1:0]   wb_rw,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_distinct,
    input  logic                   issue_valid,
    input  logic                   issue_fbank,
    input  logic [REG_IDX_W-1:0]   issue_rd,
    input  logic                   q_fbank,
    input  logic [REG_IDX_W-1:0]   q_rs,
    input  logic [REG_IDX_W-1:0]   q_rt,
    output logic                   hazard_rs,
    output logic                   hazard_rt
);

    localparam int IDX_W = $clog2(N);

    wb_req_t                  req_s [N];
    wb_req_t                  win_s;
    logic [N-1:0]             gnt_s;
    logic [IDX_W-1:0]         idx_s;
    logic                     xfer_s;
    logic                     suppress_s;
    logic                     en_r;
    logic                     fbank_r;
    logic [REG_IDX_W-1:0]     rw_r;
    logic [DATA_W-1:0]        data_r;
    logic                     distinct_r;
    logic [NUM_BANK_REGS-1:0] pend_r;
    logic [NUM_BANK_REGS-1:0] set_s;
    logic [NUM_BANK_REGS-1:0] clr_s;

    // Unpack the flat per-source request buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_s[i].fbank = req_fbank[i];
            req_s[i].rw    = req_rw[REG_IDX_W*i +: REG_IDX_W];
            req_s[i].data  = req_data[DATA_W*i +: DATA_W];
        end
    end

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
        .CLK    (CLK),
        .reset  (reset),
        .req    (req_valid),
        .en     (!wb_hold),
        .accept (xfer_s),
        .gnt    (gnt_s),
        .idx    (idx_s)
    );

    assign req_ready  = gnt_s;
    assign xfer_s     = |gnt_s;
    assign win_s      = req_s[idx_s];
    // An integer-r0 write still handshakes and clears its pending bit, but never reaches the file.
    assign suppress_s = ZERO_R0 && is_int_r0(win_s.fbank, win_s.rw);

    // Write bus register; the token flips only for writes that really happen.
    always_ff @(posedge CLK) begin
        if (reset) begin
            en_r       <= 1'b0;
            fbank_r    <= 1'b0;
            rw_r       <= {REG_IDX_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            distinct_r <= 1'b0;
        end else if (xfer_s) begin
            en_r       <= !suppress_s;
            fbank_r    <= win_s.fbank;
            rw_r       <= win_s.rw;
            data_r     <= win_s.data;
            distinct_r <= distinct_r ^ !suppress_s;
        end else begin
            en_r       <= 1'b0;
            fbank_r    <= fbank_r;
            rw_r       <= rw_r;
            data_r     <= data_r;
            distinct_r <= distinct_r;
        end
    end

    assign wb_en       = en_r;
    assign wb_fbank    = fbank_r;
    assign wb_rw       = rw_r;
    assign wb_data     = data_r;
    assign wb_distinct = distinct_r;

    assign set_s = issue_valid ? sb_onehot(issue_fbank, issue_rd) : {NUM_BANK_REGS{1'b0}};
    assign clr_s = xfer_s ? sb_onehot(win_s.fbank, win_s.rw) : {NUM_BANK_REGS{1'b0}};

    // Pending-write scoreboard; a new producer's set overrides a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pend_r <= {NUM_BANK_REGS{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_s) | set_s;
        end
    end

    assign hazard_rs = pend_r[{q_fbank, q_rs}] && !(ZERO_R0 && is_int_r0(q_fbank, q_rs));
    assign hazard_rt = pend_r[{q_fbank, q_rt}] && !(ZERO_R0 && is_int_r0(q_fbank, q_rt));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then constrained-random traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N = 4;

    logic           CLK;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_fbank;
    logic [5*N-1:0] req_rw;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           wb_hold;
    logic           wb_en;
    logic           wb_fbank;
    logic [4:0]     wb_rw;
    logic [31:0]    wb_data;
    logic           wb_distinct;
    logic           issue_valid;
    logic           issue_fbank;
    logic [4:0]     issue_rd;
    logic           q_fbank;
    logic [4:0]     q_rs;
    logic [4:0]     q_rt;
    logic           hazard_rs;
    logic           hazard_rt;

    regfile_wb_arbiter #(.N(N), .ZERO_R0(1'b1)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_fbank(req_fbank), .req_rw(req_rw), .req_data(req_data),
        .req_ready(req_ready), .wb_hold(wb_hold),
        .wb_en(wb_en), .wb_fbank(wb_fbank), .wb_rw(wb_rw), .wb_data(wb_data),
        .wb_distinct(wb_distinct),
        .issue_valid(issue_valid), .issue_fbank(issue_fbank), .issue_rd(issue_rd),
        .q_fbank(q_fbank), .q_rs(q_rs), .q_rt(q_rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr;
    int          m_last;
    bit          m_en, m_fbank, m_dist;
    bit [4:0]    m_rw;
    bit [31:0]   m_data;
    bit          m_pend [2][32];

    int          exp_grant;
    logic [N-1:0] exp_ready;
    bit          g_fb;
    bit [4:0]    g_rw;
    bit [31:0]   g_data;
    bit          exp_hrs, exp_hrt;

    function automatic int model_grant(input logic [N-1:0] v, input logic hold, input int ptr);
        int c;
        if (hold) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (ptr + k) % N;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    always_comb begin
        exp_grant = model_grant(req_valid, wb_hold, m_ptr);
        exp_ready = '0;
        g_fb      = 1'b0;
        g_rw      = 5'd0;
        g_data    = 32'd0;
        if (exp_grant >= 0) begin
            exp_ready = N'(1) << exp_grant;
            g_fb      = 1'(req_fbank >> exp_grant);
            g_rw      = 5'(req_rw >> (5 * exp_grant));
            g_data    = 32'(req_data >> (32 * exp_grant));
        end
        exp_hrs = m_pend[q_fbank][q_rs] && !(q_fbank == 1'b0 && q_rs == 5'd0);
        exp_hrt = m_pend[q_fbank][q_rt] && !(q_fbank == 1'b0 && q_rt == 5'd0);
    end

    always @(posedge CLK) begin
        if (reset) begin
            m_ptr   <= N - 1;
            m_last  <= -1;
            m_en    <= 1'b0;
            m_fbank <= 1'b0;
            m_rw    <= 5'd0;
            m_data  <= 32'd0;
            m_dist  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 32; r++)
                    m_pend[b][r] <= 1'b0;
        end else begin
            m_last <= exp_grant;
            if (exp_grant >= 0) begin
                m_ptr   <= exp_grant;
                m_en    <= !(g_fb == 1'b0 && g_rw == 5'd0);
                m_fbank <= g_fb;
                m_rw    <= g_rw;
                m_data  <= g_data;
                if (!(g_fb == 1'b0 && g_rw == 5'd0)) m_dist <= !m_dist;
                m_pend[g_fb][g_rw] <= 1'b0;
            end else begin
                m_en <= 1'b0;
            end
            if (issue_valid) m_pend[issue_fbank][issue_rd] <= 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (check_en) begin
            chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("m_wb_en", 32'(wb_en), 32'(m_en));
            chk("m_wb_distinct", 32'(wb_distinct), 32'(m_dist));
            chk("m_wb_fbank", 32'(wb_fbank), 32'(m_fbank));
            chk("m_wb_rw", 32'(wb_rw), 32'(m_rw));
            chk("m_wb_data", wb_data, m_data);
            chk("m_hazard_rs", 32'(hazard_rs), 32'(exp_hrs));
            chk("m_hazard_rt", 32'(hazard_rt), 32'(exp_hrt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic fb, input logic [4:0] rw, input logic [31:0] d);
        req_valid[i]          = v;
        req_fbank[i]          = fb;
        req_rw[5*i +: 5]      = rw;
        req_data[32*i +: 32]  = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_fbank = '0; req_rw = '0; req_data = '0;
        wb_hold = 1'b0; issue_valid = 1'b0; issue_fbank = 1'b0; issue_rd = 5'd0;
        q_fbank = 1'b0; q_rs = 5'd0; q_rt = 5'd0;
        cyc();
        cyc();
        check_en = 1'b1;
        @(negedge CLK);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_distinct", 32'(wb_distinct), 32'd0);
        chk("rst_wb_rw", 32'(wb_rw), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;

        // single source
        cyc();
        set_src(1, 1'b1, 1'b0, 5'd5, 32'h1234_5678);
        @(negedge CLK);
        chk("single_ready", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        @(negedge CLK);
        chk("single_wb_en", 32'(wb_en), 32'd1);
        chk("single_wb_rw", 32'(wb_rw), 32'd5);
        chk("single_wb_data", wb_data, 32'h1234_5678);
        chk("single_distinct", 32'(wb_distinct), 32'd1);

        // fairness
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i));
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk("fair_ready", 32'(req_ready), 32'(1) << (c % 4));
            if (c > 0) begin
                chk("fair_wb_en", 32'(wb_en), 32'd1);
                chk("fair_distinct", 32'(wb_distinct), 32'(c % 2));
            end
            cyc();
        end
        req_valid = '0;
        @(negedge CLK);
        chk("fair_last_en", 32'(wb_en), 32'd1);
        chk("fair_last_distinct", 32'(wb_distinct), 32'd0);

        // integer r0 suppression, then the float r0 write
        do_reset();
        set_src(0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        @(negedge CLK);
        chk("r0_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_fbank[0] = 1'b1;
        @(negedge CLK);
        chk("r0_wb_en", 32'(wb_en), 32'd0);
        chk("r0_distinct", 32'(wb_distinct), 32'd0);
        chk("f0_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        @(negedge CLK);
        chk("f0_wb_en", 32'(wb_en), 32'd1);
        chk("f0_distinct", 32'(wb_distinct), 32'd1);

        // scoreboard
        cyc();
        issue_valid = 1'b1; issue_fbank = 1'b1; issue_rd = 5'd7;
        cyc();
        issue_valid = 1'b0; q_fbank = 1'b1; q_rs = 5'd7; q_rt = 5'd8;
        @(negedge CLK);
        chk("sb_f7_pending", 32'(hazard_rs), 32'd1);
        chk("sb_f8_clear", 32'(hazard_rt), 32'd0);
        cyc();
        q_fbank = 1'b0;
        @(negedge CLK);
        chk("sb_i7_clear", 32'(hazard_rs), 32'd0);
        cyc();
        q_fbank = 1'b1;
        set_src(2, 1'b1, 1'b1, 5'd7, 32'h0000_0077);
        @(negedge CLK);
        chk("sb_wr_ready", 32'(req_ready), 32'b0100);
        chk("sb_no_bypass", 32'(hazard_rs), 32'd1);
        cyc();
        req_valid = '0;
        @(negedge CLK);
        chk("sb_cleared", 32'(hazard_rs), 32'd0);
        cyc();
        issue_valid = 1'b1; issue_fbank = 1'b1; issue_rd = 5'd7;
        req_valid[2] = 1'b1;
        cyc();
        issue_valid = 1'b0; req_valid = '0;
        @(negedge CLK);
        chk("sb_set_wins", 32'(hazard_rs), 32'd1);

        // hold
        cyc();
        wb_hold = 1'b1;
        set_src(3, 1'b1, 1'b0, 5'd9, 32'h0000_0033);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_wb_en", 32'(wb_en), 32'd0);
            cyc();
        end
        wb_hold = 1'b0;
        @(negedge CLK);
        chk("release_ready", 32'(req_ready), 32'b1000);
        cyc();
        req_valid = '0;
        @(negedge CLK);
        chk("release_wb_en", 32'(wb_en), 32'd1);
        chk("release_wb_rw", 32'(wb_rw), 32'd9);

        // reset in the middle of back-to-back writes
        cyc();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 5'(20 + i), 32'h5000_0000 + 32'(i));
        q_fbank = 1'b1; q_rs = 5'd7; q_rt = 5'd7;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge CLK);
        chk("mrst_wb_en", 32'(wb_en), 32'd0);
        chk("mrst_distinct", 32'(wb_distinct), 32'd0);
        chk("mrst_hazard_rs", 32'(hazard_rs), 32'd0);
        chk("mrst_hazard_rt", 32'(hazard_rt), 32'd0);
        chk("mrst_first_grant", 32'(req_ready), 32'b0001);

        // random traffic; requesters hold payload until the model says they were accepted
        for (int c = 0; c < 1500; c++) begin
            cyc();
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (reset || (req_valid[i] && m_last == i)) req_valid[i] = 1'b0;
                if (!reset && !req_valid[i] && $urandom_range(0, 1) == 1)
                    set_src(i, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            end
            wb_hold     = ($urandom_range(0, 7) == 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_fbank = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            q_fbank     = 1'($urandom_range(0, 1));
            q_rs        = 5'($urandom_range(0, 7));
            q_rt        = 5'($urandom_range(0, 7));
        end
        cyc();
        reset = 1'b0;
        req_valid = '0;
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the dual-bank (integer/float) register file between N writeback sources: ALU, FPU, load unit and UART receive.
- Round-robin arbitrates the sources with a valid/ready handshake.
- Registers the winning write onto the register-file write bus.
- Toggles the write-distinct token once per accepted write.
- Holds a 64-entry pending-write scoreboard that the issue stage queries for RAW hazards.

Parameters:
- N, 4, number of writeback requesters (2..8).
- ZERO_R0, 1, when 1 an accepted write to integer r0 completes its handshake but does not assert wb_en.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N  per-source write request
- req_fbank  in  N  per-source bank select: 1 = float, 0 = integer
- req_rw  in  5*N  per-source destination register, source i at [5i+4:5i]
- req_data  in  32*N  per-source write data, source i at [32i+31:32i]
- req_ready  out  N  per-source grant/accept, combinational
- wb_hold  in  1  freezes arbitration (no grants)
- wb_en  out  1  register-file write enable (drives RegWrite)
- wb_fbank  out  1  bank of the write (drives AorF_before)
- wb_rw  out  5  write register index
- wb_data  out  32  write data
- wb_distinct  out  1  toggles once per issued write
- issue_valid  in  1  issue stage marks a destination pending
- issue_fbank  in  1  bank of the marked destination
- issue_rd  in  5  marked destination register
- q_fbank  in  1  query bank
- q_rs  in  5  query operand 1
- q_rt  in  5  query operand 2
- hazard_rs  out  1  q_rs in bank q_fbank is pending, combinational
- hazard_rt  out  1  q_rt in bank q_fbank is pending, combinational

Behaviour:
- Reset values:
  - wb_en=0, wb_fbank=0, wb_rw=0, wb_data=0, wb_distinct=0.
  - All 64 pending bits cleared.
  - RR pointer = N-1, so source 0 has top priority on the first contest.
- Arbitration (combinational):
  - When wb_hold=0, the first valid source scanning from pointer+1 modulo N is granted.
  - req_ready is one-hot or zero.
  - req_ready[i] = req_valid[i] and granted and not wb_hold.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
- Pointer update: on a transfer the pointer loads the granted index; otherwise it holds.
- Write bus, 1-cycle latency: on a transfer at edge k, the outputs from edge k through k+1 are:
  - wb_en=1, except 0 when ZERO_R0=1 and fbank=0 and rw=0.
  - wb_fbank, wb_rw, wb_data copied from the winner.
  - wb_distinct inverted only when wb_en is 1.
- No transfer in a cycle: wb_en=0 next cycle; wb_distinct, wb_rw and wb_data hold.
- Back-to-back transfers produce wb_en high on consecutive cycles with wb_distinct alternating, so the register file's distinct-vs-buffer check accepts every write.
- Scoreboard index: {bank, reg}.
  - Set: issue_valid sets the pending bit.
  - Clear: a transfer clears the pending bit of its {req_fbank, req_rw}, including the integer-r0 case.
- Scoreboard ordering:
  - Set and clear of the same bit in one cycle: set wins, because the new producer is in flight.
  - Set and clear of different bits in one cycle: both take effect.
  - hazard outputs read the registered bits, with no same-cycle bypass of set or clear.
  - Integer r0 never reports a hazard when ZERO_R0=1.
- wb_hold: while high, no grants are made, the pointer holds, and wb_en drops to 0 the following cycle. The scoreboard still accepts issue_valid.
- Reset mid-operation: in-flight requests are dropped, wb_en is forced to 0, and wb_distinct returns to 0. The register file resets its own buffer to 0 in the same cycle, so the token remains consistent.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef wb_req_t {fbank, rw[4:0], data[31:0]}.
  - Constant REG_IDX_W=5.
  - Constant NUM_BANK_REGS=64.
- One natural sub-module, rr_arbiter (N-bit request vector in; one-hot grant and encoded index out; pointer update on accept). It is reusable for memory-port sharing.
- The scoreboard stays inline.

Test Plan:
- Single source: reset, then src1 valid with fbank=0, rw=5, data=0x12345678 for one cycle. Required: req_ready=0010 that cycle; next cycle wb_en=1, wb_rw=5, wb_data=0x12345678, wb_distinct 0→1.
- Fairness: all 4 sources valid for 8 cycles. Required: grants in order 0,1,2,3,0,1,2,3; wb_en high for 8 consecutive cycles; wb_distinct alternates 1,0,1,0,…
- r0 suppression: src0 writes integer r0, data=0xFFFFFFFF. Required: req_ready[0]=1, wb_en=0 next cycle, wb_distinct unchanged. Same request with fbank=1 gives wb_en=1.
- Scoreboard: issue marks float r7; query q_fbank=1, q_rs=7 gives hazard_rs=1 and q_fbank=0, q_rs=7 gives 0. Src2 writes f7; one cycle later hazard_rs=0. Issue and writeback of f7 in the same cycle leave the bit set.
- Hold: src3 valid with wb_hold=1 for 3 cycles. Required: req_ready=0 and wb_en=0 throughout. Release hold: grant in the same cycle, write the next cycle.
- Reset mid-stream: assert reset during back-to-back writes. Required: next cycle wb_en=0, wb_distinct=0, all hazards 0; the first post-reset grant goes to source 0.
